prog_count_n: RTL and testbench

Parametrised programmable counter, successor to the fixed 7-bit programmable counter.
- Latches a target value on a start pulse, counts toward it, and reports completion with a registered pulse.
- Supports one-shot and wrap (free-running) modes, pause/hold, and a hard ceiling clamp.
- Sits in the lab datapath wherever a terminal-count or periodic tick is needed (display scan, timed enables).

---
 rtl/prog_count_pkg.sv | 20 ++
 rtl/count_step_n.sv | 41 ++++
 rtl/prog_count_n.sv | 157 +++++++++++++++
 tb/tb_prog_count_n.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_count_pkg.sv
// prog_count_pkg
// Shared types and defaults for the programmable counter slice.
//   state_t       : controller state (IDLE, RUN, PAUSE, DONE)
//   StateWidth    : bit width of state_t
//   DefaultWidth  : default counter/target width
//   DefaultLimit  : default hard ceiling on the latched target
package prog_count_pkg;

  localparam int StateWidth   = 2;
  localparam int DefaultWidth = 7;
  localparam int DefaultLimit = 99;

  typedef enum logic [StateWidth-1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/count_step_n.sv
// count_step_n
// Bare WIDTH-bit count register. It has no knowledge of targets or modes;
// the controller decides when to clear, load or step it.
//   clk_i      : clock, rising edge
//   clear_i    : synchronous clear to zero (highest priority)
//   load_i     : load load_val_i (beats en_i)
//   load_val_i : value to load
//   en_i       : step by one this edge
//   dir_i      : step direction, 0 = up, 1 = down
//   count_o    : registered count
module count_step_n #(
  parameter int WIDTH = 7
) (
  input  logic             clk_i,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             en_i,
  input  logic             dir_i,
  output logic [WIDTH-1:0] count_o
);

  localparam logic [WIDTH-1:0] StepOne = WIDTH'(1);

  logic [WIDTH-1:0] count_q;

  // Clear beats load beats step, so the controller can fire several
  // controls at once and still get the intended result.
  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (en_i) begin
      count_q <= dir_i ? (count_q - StepOne) : (count_q + StepOne);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/prog_count_n.sv
// prog_count_n
// Programmable terminal-count / periodic-tick counter. A start pulse latches
// a clamped target and mode, the counter advances once per cycle (unless
// held) and a registered one-cycle done pulse marks each terminal hit.
// Optional feature macro: PROG_COUNT_DOWN_EN adds the dir input (count down
// from target to zero when latched high).
//   CLK       : clock, rising edge
//   reset     : synchronous active-high reset, overrides everything
//   start     : latch target/mode and (re)start
//   hold      : freeze the count while running
//   wrap      : 0 = one-shot, 1 = free-running (latched at start)
//   max_count : requested terminal value (sampled at start)
//   dir       : (PROG_COUNT_DOWN_EN only) 1 = count down (latched at start)
//   count_out : current count
//   busy      : high in RUN or PAUSE
//   paused    : high in PAUSE
//   done      : one-cycle pulse when the count becomes terminal
module prog_count_n
  import prog_count_pkg::*;
#(
  parameter int WIDTH = DefaultWidth,
  parameter int LIMIT = DefaultLimit
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             start,
  input  logic             hold,
  input  logic             wrap,
  input  logic [WIDTH-1:0] max_count,
`ifdef PROG_COUNT_DOWN_EN
  input  logic             dir,
`endif
  output logic [WIDTH-1:0] count_out,
  output logic             busy,
  output logic             paused,
  output logic             done
);

  localparam logic [WIDTH-1:0] LimitVal = WIDTH'(LIMIT);
  localparam logic [WIDTH-1:0] StepOne  = WIDTH'(1);

  state_t           state_q;
  logic [WIDTH-1:0] target_q;
  logic             wrap_q;
  logic             dir_q;
  logic             busy_q;
  logic             paused_q;
  logic             done_q;

  logic             dirIn;
  logic [WIDTH-1:0] clampedTarget;
  logic [WIDTH-1:0] startVal;
  logic [WIDTH-1:0] termVal;
  logic [WIDTH-1:0] reloadVal;
  logic [WIDTH-1:0] nextCount_d;
  logic             advance;
  logic             reload;
  logic             hit;
  logic             stepLoad;
  logic [WIDTH-1:0] stepLoadVal;
  logic             stepEn;

`ifdef PROG_COUNT_DOWN_EN
  assign dirIn = dir;
`else
  assign dirIn = 1'b0;
`endif

  assign clampedTarget = (max_count > LimitVal) ? LimitVal : max_count;
  assign startVal      = dirIn ? clampedTarget : '0;

  // The run ends on zero when counting down and on the target when counting
  // up; a wrap restarts from the opposite end.
  assign termVal   = dir_q ? '0 : target_q;
  assign reloadVal = dir_q ? target_q : '0;

  // In wrap mode the terminal value is held for one cycle, so the edge after
  // a hit reloads instead of stepping. With target 0 this reload keeps the
  // count at 0 and produces a hit every cycle.
  always_comb begin
    advance     = ((state_q == RUN) || (state_q == PAUSE)) && !hold;
    reload      = wrap_q && (count_out == termVal);
    nextCount_d = reload ? reloadVal
                         : (dir_q ? (count_out - StepOne) : (count_out + StepOne));
    hit         = advance && (nextCount_d == termVal);
  end

  assign stepLoad    = start || (advance && reload);
  assign stepLoadVal = start ? startVal : reloadVal;
  assign stepEn      = advance && !reload;

  count_step_n #(
    .WIDTH (WIDTH)
  ) u_step (
    .clk_i      (CLK),
    .clear_i    (reset),
    .load_i     (stepLoad),
    .load_val_i (stepLoadVal),
    .en_i       (stepEn),
    .dir_i      (dir_q),
    .count_o    (count_out)
  );

  // Controller and registered status outputs. Start wins over hold, so a
  // start with hold high enters RUN and only pauses on the following edge.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q  <= IDLE;
      target_q <= '0;
      wrap_q   <= 1'b0;
      dir_q    <= 1'b0;
      busy_q   <= 1'b0;
      paused_q <= 1'b0;
      done_q   <= 1'b0;
    end else if (start) begin
      target_q <= clampedTarget;
      wrap_q   <= wrap;
      dir_q    <= dirIn;
      paused_q <= 1'b0;
      if ((clampedTarget == '0) && !wrap) begin
        state_q <= DONE;
        busy_q  <= 1'b0;
        done_q  <= 1'b1;
      end else begin
        state_q <= RUN;
        busy_q  <= 1'b1;
        done_q  <= 1'b0;
      end
    end else begin
      done_q <= 1'b0;
      case (state_q)
        RUN, PAUSE: begin
          if (hold) begin
            state_q  <= PAUSE;
            paused_q <= 1'b1;
          end else begin
            paused_q <= 1'b0;
            done_q   <= hit;
            if (hit && !wrap_q) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= RUN;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign paused = paused_q;
  assign done   = done_q;

endmodule

// File: tb/tb_prog_count_n.sv
// tb_prog_count_n
// Directed bench for prog_count_n with an arithmetic reference model that is
// compared against the DUT every cycle, plus literal spot checks.
module tb_prog_count_n;

  localparam int WIDTH = 7;
  localparam int LIMIT = 99;
`ifdef PROG_COUNT_DOWN_EN
  localparam bit DownEn = 1'b1;
`else
  localparam bit DownEn = 1'b0;
`endif

  logic             CLK;
  logic             reset;
  logic             start;
  logic             hold;
  logic             wrap;
  logic [WIDTH-1:0] max_count;
  logic             dir;
  logic [WIDTH-1:0] count_out;
  logic             busy;
  logic             paused;
  logic             done;

  int checks = 0;
  int errors = 0;

  prog_count_n #(
    .WIDTH (WIDTH),
    .LIMIT (LIMIT)
  ) dut (
    .CLK       (CLK),
    .reset     (reset),
    .start     (start),
    .hold      (hold),
    .wrap      (wrap),
    .max_count (max_count),
`ifdef PROG_COUNT_DOWN_EN
    .dir       (dir),
`endif
    .count_out (count_out),
    .busy      (busy),
    .paused    (paused),
    .done      (done)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: a run is described by its target, mode and the number
  // of advancing cycles taken since start; outputs follow arithmetically.
  bit mValid   = 1'b0;
  bit mStarted = 1'b0;
  bit mWrap    = 1'b0;
  bit mDown    = 1'b0;
  bit mHeld    = 1'b0;
  bit mDone    = 1'b0;
  int mTarget  = 0;
  int mSteps   = 0;

  function automatic bit mFinished();
    return mStarted && !mWrap && (mSteps >= mTarget);
  endfunction

  function automatic int mPos();
    if (mWrap) return mSteps % (mTarget + 1);
    return (mSteps > mTarget) ? mTarget : mSteps;
  endfunction

  function automatic int mCount();
    if (!mStarted) return 0;
    return mDown ? (mTarget - mPos()) : mPos();
  endfunction

  always @(posedge CLK) begin
    mDone = 1'b0;
    if (reset) begin
      mValid   = 1'b1;
      mStarted = 1'b0;
      mHeld    = 1'b0;
      mSteps   = 0;
      mTarget  = 0;
      mWrap    = 1'b0;
      mDown    = 1'b0;
    end else if (start) begin
      mStarted = 1'b1;
      mTarget  = (int'(max_count) > LIMIT) ? LIMIT : int'(max_count);
      mWrap    = wrap;
      mDown    = DownEn && dir;
      mSteps   = 0;
      mHeld    = 1'b0;
      mDone    = (mTarget == 0) && !wrap;
    end else if (mStarted && !mFinished()) begin
      if (hold) begin
        mHeld = 1'b1;
      end else begin
        mHeld  = 1'b0;
        mSteps = mSteps + 1;
        mDone  = (mPos() == mTarget);
      end
    end
  end

  // Every-cycle comparison on the falling edge, away from the active edge.
  always @(negedge CLK) begin
    if (mValid) begin
      checkOutput("model count_out", int'(count_out), mCount());
      checkOutput("model busy", int'(busy), int'(mStarted && !mFinished()));
      checkOutput("model paused", int'(paused), int'(mStarted && !mFinished() && mHeld));
      checkOutput("model done", int'(done), int'(mDone));
    end
  end

  task automatic applyStimulus(input bit r, input bit s, input bit h, input bit w,
                               input int m, input bit d);
    reset     = r;
    start     = s;
    hold      = h;
    wrap      = w;
    max_count = WIDTH'(m);
    dir       = d;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int m);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, m, 1'b0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; hold = 1'b0; wrap = 1'b0; max_count = '0; dir = 1'b0;

    // Reset state
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 9, 1'b0);
    checkOutput("reset count_out", int'(count_out), 0);
    checkOutput("reset busy", int'(busy), 0);
    checkOutput("reset paused", int'(paused), 0);
    checkOutput("reset done", int'(done), 0);
    idle(0);
    checkOutput("idle count_out", int'(count_out), 0);

    // One-shot to 5; later max_count changes must be ignored
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 5, 1'b0);
    checkOutput("t5 start count", int'(count_out), 0);
    checkOutput("t5 start busy", int'(busy), 1);
    for (int i = 1; i <= 5; i++) begin
      idle(77);
      checkOutput("t5 count", int'(count_out), i);
      checkOutput("t5 done", int'(done), (i == 5) ? 1 : 0);
    end
    checkOutput("t5 busy after done", int'(busy), 0);
    idle(0);
    checkOutput("t5 hold count", int'(count_out), 5);
    checkOutput("t5 done once", int'(done), 0);

    // Clamp: 120 becomes 99
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 120, 1'b0);
    for (int i = 1; i <= 99; i++) begin
      idle(0);
      if (i == 98) checkOutput("clamp done early", int'(done), 0);
    end
    checkOutput("clamp count", int'(count_out), 99);
    checkOutput("clamp done", int'(done), 1);
    checkOutput("clamp busy", int'(busy), 0);

    // Wrap with target 3: period 4
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 3, 1'b0);
    for (int i = 1; i <= 12; i++) begin
      idle(0);
      checkOutput("wrap count", int'(count_out), i % 4);
      checkOutput("wrap done", int'(done), ((i % 4) == 3) ? 1 : 0);
      checkOutput("wrap busy", int'(busy), 1);
    end

    // Hold for 3 cycles at count 2, target 6
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 6, 1'b0);
    idle(0);
    idle(0);
    checkOutput("hold pre count", int'(count_out), 2);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0);
      checkOutput("hold count", int'(count_out), 2);
      checkOutput("hold paused", int'(paused), 1);
      checkOutput("hold done", int'(done), 0);
    end
    for (int i = 1; i <= 4; i++) begin
      idle(0);
      checkOutput("resume count", int'(count_out), 2 + i);
      checkOutput("resume paused", int'(paused), 0);
      checkOutput("resume done", int'(done), (i == 4) ? 1 : 0);
    end

    // Target 0 one-shot, then restart mid-run
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    checkOutput("zero done", int'(done), 1);
    checkOutput("zero busy", int'(busy), 0);
    checkOutput("zero count", int'(count_out), 0);
    idle(0);
    checkOutput("zero done once", int'(done), 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4, 1'b0);
    idle(0);
    idle(0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4, 1'b0);
    checkOutput("restart count", int'(count_out), 0);
    for (int i = 1; i <= 4; i++) idle(0);
    checkOutput("restart final count", int'(count_out), 4);
    checkOutput("restart done", int'(done), 1);

    // Wrap with target 0: stays at 0, done every cycle
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      idle(0);
      checkOutput("wrap0 count", int'(count_out), 0);
      checkOutput("wrap0 done", int'(done), 1);
      checkOutput("wrap0 busy", int'(busy), 1);
    end

    // Start with hold high: starts, then pauses before the first increment
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 2, 1'b0);
    checkOutput("starthold busy", int'(busy), 1);
    checkOutput("starthold paused", int'(paused), 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0);
    checkOutput("starthold paused2", int'(paused), 1);
    checkOutput("starthold count", int'(count_out), 0);
    idle(0);
    idle(0);
    checkOutput("starthold done", int'(done), 1);

    // Reset mid-run at count 3
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 6, 1'b0);
    for (int i = 0; i < 3; i++) idle(0);
    checkOutput("midreset pre", int'(count_out), 3);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    checkOutput("midreset count", int'(count_out), 0);
    checkOutput("midreset busy", int'(busy), 0);
    checkOutput("midreset done", int'(done), 0);
    for (int i = 0; i < 4; i++) idle(0);
    checkOutput("midreset idle", int'(count_out), 0);

`ifdef PROG_COUNT_DOWN_EN
    // Down count from 4, then down wrap from 2
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4, 1'b1);
    checkOutput("down start", int'(count_out), 4);
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
      checkOutput("down count", int'(count_out), 4 - i);
      checkOutput("down done", int'(done), (i == 4) ? 1 : 0);
    end
    idle(0);
    checkOutput("down hold zero", int'(count_out), 0);
    checkOutput("down busy", int'(busy), 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 2, 1'b1);
    for (int i = 1; i <= 6; i++) begin
      idle(0);
      checkOutput("downwrap count", int'(count_out), 2 - (i % 3));
      checkOutput("downwrap done", int'(done), ((i % 3) == 2) ? 1 : 0);
    end
`endif

    idle(0);
    idle(0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
